// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: read-return ownership tracking
// and the width constants of the memory data path.
package dmem_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int WE_W   = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CORE = 2'd1,
        RD_EXT  = 2'd2
    } rd_owner_t;

    // An access with no byte enables set is a read.
    function automatic logic is_read(input logic [WE_W-1:0] we);
        return (we == '0);
    endfunction

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating count of consecutive denied ext cycles; raises force_ext once
// ext has waited STARVE_LIMIT cycles so it cannot be starved by the core.
module arb_starve_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_req,
    input  logic ext_win,
    output logic force_ext
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt;

    // Any grant or dropped request restarts the wait; saturate at the limit.
    always_ff @(posedge clk) begin
        if (rst || !ext_req || ext_win) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign force_ext = ext_req && (cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store unit and an
// external requester; the core has priority but ext gets a bounded wait.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              core_req,
    input  logic [WE_W-1:0]   core_we,
    input  logic [AW-1:0]     core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              ext_req,
    input  logic [WE_W-1:0]   ext_we,
    input  logic [AW-1:0]     ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,

    output logic [AW-1:0]     d_addr,
    output logic [WE_W-1:0]   d_we,
    output logic [DATA_W-1:0] d_wr_data,
    input  logic [DATA_W-1:0] d_rd_data
);

    logic      core_win;
    logic      ext_win;
    logic      force_ext;
    rd_owner_t rd_owner;
    rd_owner_t rd_owner_next;

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .ext_req   (ext_req),
        .ext_win   (ext_win),
        .force_ext (force_ext)
    );

    always_comb begin
        core_win = core_req && !force_ext;
        ext_win  = ext_req && !core_win;
    end

    // With no winner the core fields still drive the pins, but writes are masked.
    always_comb begin
        d_addr    = core_addr;
        d_we      = '0;
        d_wr_data = core_wdata;
        if (core_win) begin
            d_we = core_we;
        end else if (ext_win) begin
            d_addr    = ext_addr;
            d_we      = ext_we;
            d_wr_data = ext_wdata;
        end
    end

    always_comb begin
        rd_owner_next = RD_NONE;
        if (core_win && is_read(core_we)) begin
            rd_owner_next = RD_CORE;
        end else if (ext_win && is_read(ext_we)) begin
            rd_owner_next = RD_EXT;
        end
    end

    // A read granted while rst is high must not return, so reset wins here.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner <= RD_NONE;
        end else begin
            rd_owner <= rd_owner_next;
        end
    end

    always_comb begin
        core_stall  = core_req && !core_win;
        ext_gnt     = ext_win;
        core_rvalid = (rd_owner == RD_CORE);
        ext_rvalid  = (rd_owner == RD_EXT);
        core_rdata  = d_rd_data;
        ext_rdata   = d_rd_data;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grant/mux outputs are checked each cycle,
// read returns go through a queue checked by an independent monitor.
module tb_dmem_arbiter;

    localparam int AW = 32;

    typedef struct {
        int          cyc;
        bit          is_ext;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic [3:0]  core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_stall;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        ext_req;
    logic [3:0]  ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data = '0;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    dmem_arbiter #(.STARVE_LIMIT(4), .AW(AW)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_stall  (core_stall),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .ext_req     (ext_req),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_gnt     (ext_gnt),
        .ext_rvalid  (ext_rvalid),
        .ext_rdata   (ext_rdata),
        .d_addr      (d_addr),
        .d_we        (d_we),
        .d_wr_data   (d_wr_data),
        .d_rd_data   (d_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents as seen by reads; one-cycle latency like the real SRAM.
    function automatic logic [31:0] mem_pattern(input logic [31:0] addr);
        case (addr)
            32'h100: return 32'hDEAD_BEEF;
            32'h008: return 32'h0000_8888;
            32'h00C: return 32'hCCCC_0000;
            default: return {16'hB0B0, addr[15:0]};
        endcase
    endfunction

    always @(posedge clk) d_rd_data <= mem_pattern(d_addr);

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h want=0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic apply_stimulus(
        input logic r,
        input logic creq, input logic [3:0] cwe, input logic [31:0] caddr, input logic [31:0] cwdata,
        input logic ereq, input logic [3:0] ewe, input logic [31:0] eaddr, input logic [31:0] ewdata
    );
        @(posedge clk);
        #1;
        rst        = r;
        core_req   = creq;
        core_we    = cwe;
        core_addr  = caddr;
        core_wdata = cwdata;
        ext_req    = ereq;
        ext_we     = ewe;
        ext_addr   = eaddr;
        ext_wdata  = ewdata;
        #1;
    endtask

    // Checks this cycle's grant and pins; queues the read return the
    // hand-derived winner should see on the next cycle.
    task automatic check_output(
        input string name, input logic exp_stall, input logic exp_gnt,
        input logic [31:0] exp_addr, input logic [3:0] exp_we, input logic [31:0] exp_wdata
    );
        exp_t e;
        cmp({name, ".core_stall"}, 32'(core_stall), 32'(exp_stall));
        cmp({name, ".ext_gnt"},    32'(ext_gnt),    32'(exp_gnt));
        cmp({name, ".d_addr"},     d_addr,          exp_addr);
        cmp({name, ".d_we"},       32'(d_we),       32'(exp_we));
        cmp({name, ".d_wr_data"},  d_wr_data,       exp_wdata);
        if (!rst) begin
            if (core_req && !exp_stall && core_we == 4'b0) begin
                e.cyc = cyc + 1; e.is_ext = 1'b0; e.data = mem_pattern(core_addr);
                exp_q.push_back(e);
            end else if (exp_gnt && ext_we == 4'b0) begin
                e.cyc = cyc + 1; e.is_ext = 1'b1; e.data = mem_pattern(ext_addr);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_no_rvalid(input string name);
        cmp({name, ".core_rvalid"}, 32'(core_rvalid), 32'd0);
        cmp({name, ".ext_rvalid"},  32'(ext_rvalid),  32'd0);
    endtask

    // Monitor: every rvalid must match the oldest queued return in cycle, port and data.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL missing_return got=none want=%s data 0x%0h at cycle %0d",
                     e.is_ext ? "ext" : "core", e.data, e.cyc);
        end
        if (core_rvalid && ext_rvalid) begin
            checks++;
            failures++;
            $display("[TB] FAIL rvalid_overlap got=both want=one (cycle %0d)", cyc);
        end else if (core_rvalid || ext_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_rvalid got=core:%0b ext:%0b want=none (cycle %0d)",
                         core_rvalid, ext_rvalid, cyc);
            end else begin
                e = exp_q.pop_front();
                cmp("ret.cycle", 32'(cyc), 32'(e.cyc));
                cmp("ret.is_ext", 32'(ext_rvalid), 32'(e.is_ext));
                cmp("ret.data", ext_rvalid ? ext_rdata : core_rdata, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        core_req = 1'b0; core_we = '0; core_addr = '0; core_wdata = '0;
        ext_req  = 1'b0; ext_we  = '0; ext_addr  = '0; ext_wdata  = '0;
        repeat (3) @(posedge clk);
        #2;
        check_no_rvalid("reset");
        cmp("reset.starve_cnt", 32'(u_dut.u_starve.cnt), 32'd0);

        // Core only read
        apply_stimulus(0, 1, 4'b0000, 32'h100, 32'h0, 0, 4'b0, 32'h0, 32'h0);
        check_output("core_only", 0, 0, 32'h100, 4'b0000, 32'h0);

        // Ext only write; the core read returns in the same cycle
        apply_stimulus(0, 0, 4'b0000, 32'h0, 32'h0, 1, 4'b0011, 32'h40, 32'h1234);
        check_output("ext_only", 0, 1, 32'h40, 4'b0011, 32'h1234);

        // Idle: no requests, unwinned core fields still on the pins
        apply_stimulus(0, 0, 4'b1111, 32'h55, 32'h77, 0, 4'b0, 32'h0, 32'h0);
        check_output("idle1", 0, 0, 32'h55, 4'b0000, 32'h77);
        check_no_rvalid("after_ext_write");
        apply_stimulus(0, 0, 4'b0000, 32'h55, 32'h77, 0, 4'b0, 32'h0, 32'h0);
        check_output("idle2", 0, 0, 32'h55, 4'b0000, 32'h77);
        check_no_rvalid("idle2");

        // Starvation: ext forced in its 5th requesting cycle, core back in the 6th
        for (int i = 1; i <= 6; i++) begin
            apply_stimulus(0, 1, 4'b0000, 32'h200 + 32'(4 * i), 32'h0, 1, 4'b1111, 32'h80, 32'hA5A5);
            if (i == 5)
                check_output($sformatf("starve%0d", i), 1, 1, 32'h80, 4'b1111, 32'hA5A5);
            else
                check_output($sformatf("starve%0d", i), 0, 0, 32'h200 + 32'(4 * i), 4'b0000, 32'h0);
        end

        // Interleaved reads: core then ext, returns on consecutive cycles
        apply_stimulus(0, 1, 4'b0000, 32'h8, 32'h0, 0, 4'b0, 32'h0, 32'h0);
        check_output("inter_core", 0, 0, 32'h8, 4'b0000, 32'h0);
        apply_stimulus(0, 0, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 32'hC, 32'h0);
        check_output("inter_ext", 0, 1, 32'hC, 4'b0000, 32'h0);
        apply_stimulus(0, 0, 4'b0000, 32'h0, 32'h0, 0, 4'b0, 32'h0, 32'h0);
        check_output("inter_idle", 0, 0, 32'h0, 4'b0000, 32'h0);

        // Reset mid-read: contention first so the counter is non-zero
        apply_stimulus(0, 1, 4'b0000, 32'h300, 32'h0, 1, 4'b1111, 32'h90, 32'h1);
        check_output("pre_reset", 0, 0, 32'h300, 4'b0000, 32'h0);
        apply_stimulus(1, 1, 4'b0000, 32'h100, 32'h0, 1, 4'b1111, 32'h90, 32'h1);
        check_output("reset_read", 0, 0, 32'h100, 4'b0000, 32'h0);
        cmp("reset_read.starve_cnt", 32'(u_dut.u_starve.cnt), 32'd1);
        apply_stimulus(0, 0, 4'b0000, 32'h0, 32'h0, 0, 4'b0, 32'h0, 32'h0);
        check_no_rvalid("after_reset");
        cmp("after_reset.starve_cnt", 32'(u_dut.u_starve.cnt), 32'd0);

        repeat (3) @(posedge clk);
        #2;
        cmp("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the core load/store unit (core port) and an external requester such as a debug or program loader (ext port). Arbitration is fixed-priority to the core with a bounded starvation guarantee for ext. The block sits between the load/store unit's `d_*` memory pins and the data memory. It routes the one-cycle-latency read data back to whichever port issued the read.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive denied ext cycles before ext is forced a grant; legal range is 1..255.
- `AW`, default 32: address width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `core_req` in 1: core access request this cycle.
- `core_we` in 4: core byte write enables; 0 means read.
- `core_addr` in AW: core address.
- `core_wdata` in 32: core write data.
- `core_stall` out 1: core request not granted this cycle; the core must hold the request.
- `core_rvalid` out 1: core read data valid.
- `core_rdata` out 32: core read data.
- `ext_req` in 1: ext request; held with stable fields until `ext_gnt`.
- `ext_we` in 4: ext byte write enables.
- `ext_addr` in AW: ext address.
- `ext_wdata` in 32: ext write data.
- `ext_gnt` out 1: ext access accepted this cycle.
- `ext_rvalid` out 1: ext read data valid.
- `ext_rdata` out 32: ext read data.
- `d_addr` out AW: memory address.
- `d_we` out 4: memory byte write enables.
- `d_wr_data` out 32: memory write data.
- `d_rd_data` in 32: memory read data; valid the cycle after the address is presented.

## Operation
- Grant decision is combinational each cycle:
  - The core wins if `core_req` is high and `force_ext` is low.
  - Otherwise ext wins if `ext_req` is high.
  - `force_ext` is defined as `ext_req && starve_cnt == STARVE_LIMIT`.
- Winner's `addr`/`we`/`wdata` drive the `d_*` pins.
- With no winner:
  - `d_we` = 0.
  - `d_addr` = `core_addr`.
  - `d_wr_data` = `core_wdata`.
- `core_stall` = `core_req && !core_win`.
- `ext_gnt` = `ext_win`.
- `starve_cnt`, 8 bits:
  - Cleared on reset, on `ext_win`, or when `ext_req` is low.
  - Increments when `ext_req && !ext_win`.
  - Saturates at `STARVE_LIMIT`.
- Read return tracking:
  - Registered `rd_owner`, with values NONE/CORE/EXT, captures the winner of a read (winner's `we` == 0).
  - A write or an idle cycle captures NONE.
- Next cycle:
  - `core_rvalid` = (`rd_owner` == CORE).
  - `ext_rvalid` = (`rd_owner` == EXT).
  - Both `rdata` outputs = `d_rd_data` unmodified. Sign/zero extension stays in the load/store unit.
- Write returns no response. The grant cycle is the completion.
- Back-to-back grants are legal every cycle. A new grant may coincide with the return of the previous read.

## Timing
- Reset values:
  - `core_rvalid` = 0, `ext_rvalid` = 0.
  - `rd_owner` = NONE, `starve_cnt` = 0.
  - `core_rdata`/`ext_rdata` follow `d_rd_data` and are don't-care while their `rvalid` is low.
- Reset mid-read: a read granted in the cycle `rst` is high produces no `rvalid` the next cycle.
- Latency:
  - Grant: 0 cycles, combinational.
  - Read data: 1 cycle after grant.
  - Uncontended stall: 0.
- Worst-case ext wait under continuous core traffic is `STARVE_LIMIT` denied cycles, with the grant on the next cycle. With the default of 4, ext is granted in its 5th requesting cycle.
- When ext is forced, the core stalls exactly one cycle. `starve_cnt` is 0 afterwards, so the core wins the following cycle.
- Simultaneous `core_req` and `ext_req` with `starve_cnt` < limit: the core wins.
- `ext_req` dropped before grant violates the protocol. The counter clears and nothing else is affected.

## Structure
- The `rd_owner_t` enum (NONE/CORE/EXT) goes in `defines.svh` alongside `load_op_t`/`store_op_t`.
- Sub-module `arb_starve_cnt` holds the saturating counter and the `force_ext` compare. It is parameterized by `STARVE_LIMIT`.
- The top level holds the grant logic, the `d_*` mux, and the `rd_owner` register with the return demux.

## Test plan
- **Core only.** Core reads 0x100 with `we`=0 while memory returns 0xDEADBEEF. Expect `core_stall`=0 and `d_addr`=0x100, then next cycle `core_rvalid`=1 and `core_rdata`=0xDEADBEEF, with `ext_rvalid`=0.
- **Ext only.** Ext writes `we`=4'b0011, addr 0x40, data 0x1234. Expect `ext_gnt`=1 the same cycle, `d_we`=0011, `d_wr_data`=0x1234, and no `rvalid` on either port.
- **Starvation.** Hold `core_req` and `ext_req` continuously with `STARVE_LIMIT`=4. Expect `ext_gnt` low for 4 cycles, high in cycle 5 with `core_stall`=1, then the core wins in cycle 6.
- **Interleaved reads.** Core read at 0x8, then ext read at 0xC in the following cycle. Expect `core_rvalid` in cycle 2 and `ext_rvalid` in cycle 3, with the data routed to the correct port and no overlap of the `rvalid`s.
- **Reset mid-read.** Assert `rst` in the cycle a core read is granted. Expect `core_rvalid`=0 the next cycle and `starve_cnt`=0.
- **Idle.** No requests. Expect `d_we`=0, both `rvalid`s at 0, `core_stall`=0 and `ext_gnt`=0.
